// File: rtl/bcd_serial_adder.sv
// Digit-serial BCD adder: one digit pair per clock through a bcd_adder cell.
// Optional non-BCD digit flag on `invalid` with BCD_SERIAL_INVALID_CHECK_EN.

module bcd_adder (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] s,
   output logic       cout
);

   logic [4:0] bin;

   always_comb begin
      bin = {1'b0, a} + {1'b0, b} + {4'b0, cin};
      if (bin > 5'd9) begin
         s    = 4'(bin + 5'd6);
         cout = 1'b1;
      end else begin
         s    = bin[3:0];
         cout = 1'b0;
      end
   end

endmodule

module bcd_serial_adder #(
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [4*DIGITS-1:0]   a,
   input  logic [4*DIGITS-1:0]   b,
   input  logic                  cin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   sum,
   output logic                  cout
`ifdef BCD_SERIAL_INVALID_CHECK_EN
   ,
   output logic                  invalid
`endif
);

   localparam int W = 4 * DIGITS;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t        state;
   logic [W-1:0]  a_sh;
   logic [W-1:0]  b_sh;
   logic [W-1:0]  work;
   logic          carry;
   logic [4:0]    cnt;

   logic [3:0]    cell_s;
   logic          cell_cout;
   logic [W-1:0]  work_next;
   logic          last;

   bcd_adder u_cell (
      .a    (a_sh[3:0]),
      .b    (b_sh[3:0]),
      .cin  (carry),
      .s    (cell_s),
      .cout (cell_cout)
   );

   // New digit enters at the top; after DIGITS shifts digit 0 sits at the bottom.
   assign work_next = W'({cell_s, work} >> 4);
   assign last      = (cnt == 5'(DIGITS - 1));

`ifdef BCD_SERIAL_INVALID_CHECK_EN
   logic inv_acc;
   logic dig_bad;

   assign dig_bad = (a_sh[3:0] > 4'd9) || (b_sh[3:0] > 4'd9);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         a_sh  <= '0;
         b_sh  <= '0;
         work  <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         sum   <= '0;
         cout  <= 1'b0;
`ifdef BCD_SERIAL_INVALID_CHECK_EN
         inv_acc <= 1'b0;
         invalid <= 1'b0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_sh  <= a;
                  b_sh  <= b;
                  carry <= cin;
                  work  <= '0;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
`ifdef BCD_SERIAL_INVALID_CHECK_EN
                  inv_acc <= 1'b0;
`endif
               end
            end
            RUN: begin
               work  <= work_next;
               carry <= cell_cout;
               a_sh  <= a_sh >> 4;
               b_sh  <= b_sh >> 4;
               cnt   <= cnt + 5'd1;
`ifdef BCD_SERIAL_INVALID_CHECK_EN
               inv_acc <= inv_acc | dig_bad;
`endif
               if (last) begin
                  sum   <= work_next;
                  cout  <= cell_cout;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
`ifdef BCD_SERIAL_INVALID_CHECK_EN
                  invalid <= inv_acc | dig_bad;
`endif
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
